// File: rtl/key_input.sv
// key_input: synchronises and debounces the up/down/start buttons and turns held
// up/down keys into rate-limited step strobes plus a stretched BEGIN pulse.
// Build option: define KEY_GRAVITY_EN to add the FALL state, which strobes down periodically once started.
//
// state | meaning
// IDLE  | no single direction key held (neither, or both)
// UP    | only up held; up_key_press every STEP_CYC cycles
// DOWN  | only down held; down_key_press every STEP_CYC cycles
// FALL  | (KEY_GRAVITY_EN) started, no key held; down_key_press every FALL_CYC cycles
module key_input #(
  parameter int DEB_CYC    = 1_000_000,
  parameter int STEP_CYC   = 200_000,
  parameter int FALL_CYC   = 400_000,
  parameter int START_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_start,
  output logic       up_key_press,
  output logic       down_key_press,
  output logic       BEGIN,
  output logic [2:0] key_state
);

  localparam logic [23:0] DEB_TC  = 24'(DEB_CYC - 1);
  localparam logic [23:0] STEP_TC = 24'(STEP_CYC - 1);
  localparam logic [23:0] HOLD_LD = 24'(START_HOLD);

  if (DEB_CYC < 1 || STEP_CYC < 1 || FALL_CYC < 1 || START_HOLD < 4 ||
      DEB_CYC >= 2**24 || STEP_CYC >= 2**24 || FALL_CYC >= 2**24 ||
      START_HOLD >= 2**24) begin : g_param_check
    $error("key_input: cycle parameter out of range");
  end

`ifdef KEY_GRAVITY_EN
  localparam logic [23:0] FALL_TC = 24'(FALL_CYC - 1);
  typedef enum logic [1:0] {IDLE, UP, DOWN, FALL} step_state_t;
`else
  typedef enum logic [1:0] {IDLE, UP, DOWN} step_state_t;
`endif

  logic [2:0]  sync_a;
  logic [2:0]  sync_b;
  logic [2:0]  deb;
  logic [23:0] deb_cnt [3];

  logic        start_q;
  logic        start_rise;
  logic [23:0] hold_cnt;

  step_state_t state, state_nxt;
  logic [23:0] step_cnt, step_cnt_nxt;
  logic        up_nxt;
  logic        down_nxt;

`ifdef KEY_GRAVITY_EN
  logic        started;
`endif

  assign key_state  = deb;
  assign BEGIN      = (hold_cnt != 24'd0);
  assign start_rise = deb[2] & ~start_q;

  // bit order {start, down, up} matches key_state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a <= '0;
      sync_b <= '0;
      deb    <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync_a <= {key_start, key_down, key_up};
      sync_b <= sync_a;
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_TC) begin
          deb[i]     <= sync_b[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 24'd1;
        end
      end
    end
  end

  // a rising edge while the pulse is still running does not retrigger it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      start_q <= deb[2];
      if (start_rise && hold_cnt == 24'd0) hold_cnt <= HOLD_LD;
      else if (hold_cnt != 24'd0)          hold_cnt <= hold_cnt - 24'd1;
    end
  end

`ifdef KEY_GRAVITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          started <= 1'b0;
    else if (start_rise) started <= 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      step_cnt       <= '0;
      up_key_press   <= 1'b0;
      down_key_press <= 1'b0;
    end else begin
      state          <= state_nxt;
      step_cnt       <= step_cnt_nxt;
      up_key_press   <= up_nxt;
      down_key_press <= down_nxt;
    end
  end

  always_comb begin
    state_nxt    = IDLE;
    step_cnt_nxt = '0;
    up_nxt       = 1'b0;
    down_nxt     = 1'b0;

    if (deb[0] && !deb[1])      state_nxt = UP;
    else if (deb[1] && !deb[0]) state_nxt = DOWN;
`ifdef KEY_GRAVITY_EN
    else if (!deb[0] && !deb[1] && started) state_nxt = FALL;
`endif

    // entering UP/DOWN strobes at once; entering FALL waits a full period
    if (state_nxt != state) begin
      up_nxt   = (state_nxt == UP);
      down_nxt = (state_nxt == DOWN);
    end else if (state == UP || state == DOWN) begin
      if (step_cnt == STEP_TC) begin
        up_nxt   = (state == UP);
        down_nxt = (state == DOWN);
      end else begin
        step_cnt_nxt = step_cnt + 24'd1;
      end
    end
`ifdef KEY_GRAVITY_EN
    else if (state == FALL) begin
      if (step_cnt == FALL_TC) down_nxt = 1'b1;
      else                     step_cnt_nxt = step_cnt + 24'd1;
    end
`endif
  end

endmodule

// File: tb/tb_key_input.sv
// Directed bench for key_input with DEB_CYC=4, STEP_CYC=10, FALL_CYC=16, START_HOLD=8.
// Cycle k means the values just after the k-th rising edge once the stimulus phase starts.
module tb_key_input;

  localparam int DEB  = 4;
  localparam int STEP = 10;
  localparam int FALL = 16;
  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_up = 1'b0;
  logic       key_down = 1'b0;
  logic       key_start = 1'b0;
  logic       up_key_press;
  logic       down_key_press;
  logic       begin_pulse;
  logic [2:0] key_state;

  int vectors = 0;
  int miscompares = 0;

  key_input #(
    .DEB_CYC(DEB), .STEP_CYC(STEP), .FALL_CYC(FALL), .START_HOLD(HOLD)
  ) dut (
    .clk(clk), .reset(reset),
    .key_up(key_up), .key_down(key_down), .key_start(key_start),
    .up_key_press(up_key_press), .down_key_press(down_key_press),
    .BEGIN(begin_pulse), .key_state(key_state)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    key_up = 1'b0; key_down = 1'b0; key_start = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [2:0] exp_ks;
    logic       exp_b;
    key_up = 1'b1; key_down = 1'b1; key_start = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({up_key_press, down_key_press, begin_pulse, key_state} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want 000000",
               {up_key_press, down_key_press, begin_pulse, key_state});
    end
    reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      exp_ks = (k >= 6) ? 3'b111 : 3'b000;
      exp_b  = (k >= 7 && k <= 14);
      vectors++;
      if (key_state !== exp_ks) begin
        miscompares++;
        $display("FAIL reset_key_state cycle %0d got %b want %b", k, key_state, exp_ks);
      end
      vectors++;
      if (begin_pulse !== exp_b) begin
        miscompares++;
        $display("FAIL reset_begin cycle %0d got %b want %b", k, begin_pulse, exp_b);
      end
      vectors++;
      if ({up_key_press, down_key_press} !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_strobes cycle %0d got %b want 00", k,
                 {up_key_press, down_key_press});
      end
    end
  endtask

  task automatic test_debounce();
    logic exp_up, exp_ks;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      key_up = (k <= 3);
      @(posedge clk); #1;
      vectors++;
      if (key_state !== 3'b000 || up_key_press !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch cycle %0d got ks=%b up=%b want ks=000 up=0", k, key_state, up_key_press);
      end
    end
    for (int k = 1; k <= 60; k++) begin
      key_up = (k <= 40);
      @(posedge clk); #1;
      exp_up = (k == 7 || k == 17 || k == 27 || k == 37);
      exp_ks = (k >= 6 && k <= 45);
      vectors++;
      if (up_key_press !== exp_up || down_key_press !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_up_strobe cycle %0d got up=%b down=%b want up=%b down=0",
                 k, up_key_press, down_key_press, exp_up);
      end
      vectors++;
      if (key_state !== {2'b00, exp_ks}) begin
        miscompares++;
        $display("FAIL hold_up_key_state cycle %0d got %b want %b", k, key_state, {2'b00, exp_ks});
      end
    end
  endtask

  task automatic test_direction();
    logic exp_up, exp_dn;
    logic [2:0] exp_ks;
    do_reset();
    for (int k = 1; k <= 45; k++) begin
      key_down = (k <= 25);
      key_up   = (k >= 26);
      @(posedge clk); #1;
      exp_dn = (k == 7 || k == 17 || k == 27);
      exp_up = (k == 32 || k == 42);
      exp_ks = {1'b0, (k >= 6 && k <= 30), (k >= 31)};
      vectors++;
      if (up_key_press !== exp_up || down_key_press !== exp_dn) begin
        miscompares++;
        $display("FAIL direction_strobes cycle %0d got up=%b down=%b want up=%b down=%b",
                 k, up_key_press, down_key_press, exp_up, exp_dn);
      end
      vectors++;
      if ((up_key_press & down_key_press) !== 1'b0) begin
        miscompares++;
        $display("FAIL strobe_exclusive cycle %0d got both=%b want 0", k,
                 up_key_press & down_key_press);
      end
      vectors++;
      if (key_state !== exp_ks) begin
        miscompares++;
        $display("FAIL direction_key_state cycle %0d got %b want %b", k, key_state, exp_ks);
      end
    end
  endtask

  task automatic test_start();
    logic exp_b, exp_ks2, exp_dn;
    do_reset();
    for (int k = 1; k <= 85; k++) begin
      key_start = (k <= 4) || (k >= 9 && k <= 40) || (k >= 61);
      @(posedge clk); #1;
      exp_ks2 = (k >= 6 && k <= 9) || (k >= 14 && k <= 45) || (k >= 66);
      exp_b   = (k >= 7 && k <= 14) || (k >= 67 && k <= 74);
`ifdef KEY_GRAVITY_EN
      exp_dn  = (k >= 24) && ((k - 24) % 16 == 0);
`else
      exp_dn  = 1'b0;
`endif
      vectors++;
      if (begin_pulse !== exp_b) begin
        miscompares++;
        $display("FAIL start_begin cycle %0d got %b want %b", k, begin_pulse, exp_b);
      end
      vectors++;
      if (key_state[2] !== exp_ks2) begin
        miscompares++;
        $display("FAIL start_key_state cycle %0d got %b want %b", k, key_state[2], exp_ks2);
      end
      vectors++;
      if (up_key_press !== 1'b0 || down_key_press !== exp_dn) begin
        miscompares++;
        $display("FAIL start_strobes cycle %0d got up=%b down=%b want up=0 down=%b",
                 k, up_key_press, down_key_press, exp_dn);
      end
    end
  endtask

`ifdef KEY_GRAVITY_EN
  task automatic test_gravity();
    logic exp_up, exp_dn;
    do_reset();
    for (int k = 1; k <= 80; k++) begin
      key_start = (k <= 10);
      key_up    = (k >= 60);
      @(posedge clk); #1;
      exp_dn = (k == 24 || k == 40 || k == 56);
      exp_up = (k == 66 || k == 76);
      vectors++;
      if (up_key_press !== exp_up || down_key_press !== exp_dn) begin
        miscompares++;
        $display("FAIL gravity_strobes cycle %0d got up=%b down=%b want up=%b down=%b",
                 k, up_key_press, down_key_press, exp_up, exp_dn);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic exp_up, exp_b;
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      key_up = 1'b1; key_start = 1'b1;
      @(posedge clk); #1;
      exp_up = (k == 7 || k == 17);
      exp_b  = (k >= 7 && k <= 14);
      vectors++;
      if (up_key_press !== exp_up || begin_pulse !== exp_b) begin
        miscompares++;
        $display("FAIL pre_reset cycle %0d got up=%b begin=%b want up=%b begin=%b",
                 k, up_key_press, begin_pulse, exp_up, exp_b);
      end
    end
    reset = 1'b0;
    key_start = 1'b0;
    #1;
    vectors++;
    if ({up_key_press, down_key_press, begin_pulse, key_state} !== 6'b0) begin
      miscompares++;
      $display("FAIL async_reset got %b want 000000",
               {up_key_press, down_key_press, begin_pulse, key_state});
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      exp_up = (k == 7 || k == 17);
      vectors++;
      if (up_key_press !== exp_up || down_key_press !== 1'b0 || begin_pulse !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_held cycle %0d got up=%b down=%b begin=%b want up=%b down=0 begin=0",
                 k, up_key_press, down_key_press, begin_pulse, exp_up);
      end
      vectors++;
      if (key_state !== {2'b00, (k >= 6)}) begin
        miscompares++;
        $display("FAIL post_reset_key_state cycle %0d got %b want %b", k, key_state,
                 {2'b00, (k >= 6)});
      end
    end
    for (int k = 1; k <= 40; k++) begin
      key_up = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if ({up_key_press, down_key_press} !== 2'b00) begin
        miscompares++;
        $display("FAIL post_reset_idle cycle %0d got %b want 00", k,
                 {up_key_press, down_key_press});
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_direction();
    test_start();
`ifdef KEY_GRAVITY_EN
    test_gravity();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
